// File: rtl/seg_scan_ctrl_if.sv
// Digit-buffer write channel for seg_scan_ctrl.
//   wr_valid : write request (master -> slave)
//   wr_ready : write accepted when high together with wr_valid (slave -> master)
//   wr_addr  : digit index 0..5; 6 and 7 are rejected
//   wr_data  : hex nibble for the digit
//   wr_dp    : decimal point for the digit
//   wr_err   : one-cycle pulse after an accepted write to an invalid index
interface seg_scan_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       wr_err;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_dp,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_dp,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan controller with PWM brightness.
// Each enabled digit is shown for 16 slots of SLOT_CYC cycles, lit only in
// slots 0..brightness, separated by BLANK_CYC cycles of full blanking.
//   clk        : sole clock
//   rst        : asynchronous active-high reset
//   wr         : digit-buffer write channel (slave side)
//   en_mask    : per-digit scan enable
//   brightness : lit slots minus one
//   SEG        : active-high segments, bit7 = dp, bits6..0 = g..a (registered)
//   DIG        : active-high one-hot digit select (registered)
//   frame_tick : one-cycle pulse when the scan wraps around (registered)
module seg_scan_ctrl #(
  parameter int unsigned SLOT_CYC  = 3125,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_ctrl_if.slave        wr,
  input  logic [5:0]            en_mask,
  input  logic [3:0]            brightness,
  output logic [7:0]            SEG,
  output logic [5:0]            DIG,
  output logic                  frame_tick
);

  localparam int unsigned CntMax = (SLOT_CYC > BLANK_CYC) ? SLOT_CYC : BLANK_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [0:0] StBlank = 1'b0;
  localparam logic [0:0] StShow  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;     // blanking cycles, or cycles within a slot
  logic [3:0]      slot_q, slot_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0]      bright_q, bright_d;
  logic [4:0]      buf_q [6];        // {dp, nibble}
  logic [5:0]      dig_q, dig_d;
  logic [7:0]      seg_q, seg_d;
  logic            ft_q, ft_d;
  logic            err_q, err_d;

  logic       wr_acc;
  logic [2:0] sel;
  logic       found;
  logic [3:0] cand;
  logic [4:0] sel_ent;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    unique case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

  assign wr.wr_ready = (state_q == StBlank);
  assign wr_acc      = wr.wr_valid & wr.wr_ready;

  // First enabled digit after idx_q, wrapping; reaches idx_q itself last.
  always_comb begin
    sel   = idx_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= 6; k++) begin
      cand = {1'b0, idx_q} + 4'(k);
      if (cand >= 4'd6) cand = cand - 4'd6;
      if (!found && en_mask[cand[2:0]]) begin
        found = 1'b1;
        sel   = cand[2:0];
      end
    end
  end

  // Forward a same-edge write so the selected digit shows fresh data at once.
  assign sel_ent = (wr_acc && (wr.wr_addr == sel)) ? {wr.wr_dp, wr.wr_data} : buf_q[sel];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    idx_d    = idx_q;
    bright_d = bright_q;
    dig_d    = '0;
    seg_d    = '0;
    ft_d     = 1'b0;
    err_d    = wr_acc && (wr.wr_addr > 3'd5);
    if (state_q == StBlank) begin
      if (cnt_q == CntW'(BLANK_CYC - 1)) begin
        cnt_d = '0;
        if (|en_mask) begin
          state_d  = StShow;
          slot_d   = '0;
          idx_d    = sel;
          bright_d = brightness;
          dig_d    = 6'b1 << sel;
          seg_d    = {sel_ent[4], hex7(sel_ent[3:0])};
          ft_d     = (sel <= idx_q);
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      if ((slot_q == 4'hF) && (cnt_q == CntW'(SLOT_CYC - 1))) begin
        state_d = StBlank;
        cnt_d   = '0;
      end else begin
        if (cnt_q == CntW'(SLOT_CYC - 1)) begin
          cnt_d  = '0;
          slot_d = slot_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (slot_d <= bright_q) begin
          dig_d = 6'b1 << idx_q;
          seg_d = {buf_q[idx_q][4], hex7(buf_q[idx_q][3:0])};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StBlank;
      cnt_q    <= '0;
      slot_q   <= '0;
      idx_q    <= 3'd5;
      bright_q <= '0;
      dig_q    <= '0;
      seg_q    <= '0;
      ft_q     <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < 6; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      bright_q <= bright_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      ft_q     <= ft_d;
      err_q    <= err_d;
      if (wr_acc && (wr.wr_addr <= 3'd5)) buf_q[wr.wr_addr] <= {wr.wr_dp, wr.wr_data};
    end
  end

  assign DIG        = dig_q;
  assign SEG        = seg_q;
  assign frame_tick = ft_q;
  assign wr.wr_err  = err_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl with a timeline model.
module tb_seg_scan_ctrl;
  localparam int SlotCyc  = 2;
  localparam int BlankCyc = 3;
  localparam int ShowCyc  = 16 * SlotCyc;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] en_mask;
  logic [3:0] brightness;
  logic [7:0] SEG;
  logic [5:0] DIG;
  logic       frame_tick;

  seg_scan_ctrl_if wr_if ();

  seg_scan_ctrl #(.SLOT_CYC(SlotCyc), .BLANK_CYC(BlankCyc)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr_if),
    .en_mask   (en_mask),
    .brightness(brightness),
    .SEG       (SEG),
    .DIG       (DIG),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: phase, elapsed cycles in that phase, digit shown, sampled brightness.
  bit         m_show;
  int         m_t;
  int         m_idx;
  int         m_bright;
  logic [4:0] m_buf [6];
  bit         m_ft;
  bit         m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_show = 0; m_t = 0; m_idx = 5; m_bright = 0; m_ft = 0; m_err = 0;
    for (int i = 0; i < 6; i++) m_buf[i] = '0;
  endtask

  task automatic model_step();
    int  nxt;
    int  c;
    bit  fnd;
    m_ft  = 0;
    m_err = 0;
    if (!m_show) begin
      if (wr_if.wr_valid) begin
        if (wr_if.wr_addr < 6) m_buf[wr_if.wr_addr] = {wr_if.wr_dp, wr_if.wr_data};
        else m_err = 1;
      end
      if (m_t == BlankCyc - 1) begin
        m_t = 0;
        if (en_mask != 0) begin
          nxt = m_idx;
          fnd = 0;
          for (int k = 1; k <= 6; k++) begin
            c = (m_idx + k) % 6;
            if (!fnd && en_mask[c]) begin fnd = 1; nxt = c; end
          end
          m_ft     = (nxt <= m_idx);
          m_idx    = nxt;
          m_bright = brightness;
          m_show   = 1;
        end
      end else m_t++;
    end else begin
      if (m_t == ShowCyc - 1) begin m_show = 0; m_t = 0; end
      else m_t++;
    end
  endtask

  task automatic compare_all();
    logic [5:0] ed;
    logic [7:0] es;
    ed = '0;
    es = '0;
    if (m_show && (m_t / SlotCyc) <= m_bright) begin
      ed = 6'(1 << m_idx);
      es = {m_buf[m_idx][4], hex_tbl[m_buf[m_idx][3:0]]};
    end
    check("DIG", 32'(DIG), 32'(ed));
    check("SEG", 32'(SEG), 32'(es));
    check("frame_tick", 32'(frame_tick), 32'(m_ft));
    check("wr_err", 32'(wr_if.wr_err), 32'(m_err));
    check("wr_ready", 32'(wr_if.wr_ready), 32'(!m_show));
  endtask

  // Inputs are already driven for the coming edge; called and returns at negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  task automatic wait_dig(input string name, input logic [5:0] target, input int limit);
    int n;
    n = 0;
    while (DIG !== target && n < limit) begin tick(); n++; end
    if (DIG !== target) check(name, 32'(DIG), 32'(target));
  endtask

  int         ft_cnt, on_cnt, d0_cnt, err_cnt, rdy_cnt, entries;
  logic [5:0] prev_dig;
  logic [5:0] order [4];
  bit         acc;

  initial begin
    rst = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    wr_if.wr_dp    = 1'b0;
    en_mask        = 6'h3F;
    brightness     = 4'hF;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_all();
    check("reset_dig", 32'(DIG), 32'h0);

    // Default buffer, all enabled, full brightness.
    ft_cnt = 0; d0_cnt = 0;
    for (int i = 1; i <= 38; i++) begin
      tick();
      ft_cnt += int'(frame_tick);
      if (DIG == 6'b000001) d0_cnt++;
      if (i == 3) begin
        check("first_dig", 32'(DIG), 32'h01);
        check("first_seg", 32'(SEG), 32'h3F);
        check("first_tick", 32'(frame_tick), 32'h1);
      end
      if (i == 38) check("second_dig", 32'(DIG), 32'h02);
    end
    check("digit0_cycles", 32'(d0_cnt), 32'd32);
    check("tick_count_a", 32'(ft_cnt), 32'd1);

    // Write digit 2 = A with dp, held until the handshake completes.
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 3'd2; wr_if.wr_data = 4'hA; wr_if.wr_dp = 1'b1;
    acc = 0;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = wr_if.wr_ready;
      tick();
    end
    check("handshake_done", 32'(acc), 32'h1);
    wr_if.wr_valid = 1'b0;
    wait_dig("wait_digit2", 6'b000100, 200);
    check("digit2_seg", 32'(SEG), 32'hF7);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      wr_if.wr_valid = ($urandom_range(3) == 0);
      wr_if.wr_addr  = 3'($urandom_range(7));
      wr_if.wr_data  = 4'($urandom);
      wr_if.wr_dp    = 1'($urandom);
      brightness     = 4'($urandom);
      if ($urandom_range(59) == 0) begin
        case ($urandom_range(3))
          0: en_mask = 6'h00;
          1: en_mask = 6'(1 << $urandom_range(5));
          default: en_mask = 6'($urandom);
        endcase
      end
      tick();
    end
    wr_if.wr_valid = 1'b0;

    // Two-digit scan at brightness 3 from reset.
    en_mask = 6'b100100; brightness = 4'd3;
    do_reset();
    ft_cnt = 0; on_cnt = 0; entries = 0; prev_dig = '0; d0_cnt = 0;
    for (int i = 1; i <= 140; i++) begin
      tick();
      ft_cnt += int'(frame_tick);
      if (DIG != 0) on_cnt++;
      if (i <= 34 && DIG != 0) d0_cnt++;
      if (DIG != 0 && prev_dig == 0 && entries < 4) begin order[entries] = DIG; entries++; end
      prev_dig = DIG;
    end
    check("entries", 32'(entries), 32'd4);
    check("order0", 32'(order[0]), 32'h04);
    check("order1", 32'(order[1]), 32'h20);
    check("order2", 32'(order[2]), 32'h04);
    check("order3", 32'(order[3]), 32'h20);
    check("tick_count_d", 32'(ft_cnt), 32'd2);
    check("lit_cycles_first", 32'(d0_cnt), 32'd8);
    check("lit_cycles_total", 32'(on_cnt), 32'd32);

    // Nothing enabled: stays dark, no ticks.
    en_mask = 6'h00;
    ft_cnt = 0; on_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      ft_cnt += int'(frame_tick);
      if (DIG != 0) on_cnt++;
    end
    check("idle_lit", 32'(on_cnt), 32'd0);
    check("idle_ticks", 32'(ft_cnt), 32'd0);

    // Invalid address write.
    err_cnt = 0;
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 3'd7; wr_if.wr_data = 4'h8; wr_if.wr_dp = 1'b1;
    tick();
    err_cnt += int'(wr_if.wr_err);
    wr_if.wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); err_cnt += int'(wr_if.wr_err); end
    check("err_pulses", 32'(err_cnt), 32'd1);

    // Write held through SHOW is not accepted until BLANK.
    en_mask = 6'h3F; brightness = 4'hF;
    wait_dig("wait_show", 6'b000001, 20);
    wr_if.wr_valid = 1'b1; wr_if.wr_addr = 3'd0; wr_if.wr_data = 4'h5; wr_if.wr_dp = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 10; i++) begin rdy_cnt += int'(wr_if.wr_ready); tick(); end
    check("ready_in_show", 32'(rdy_cnt), 32'd0);
    acc = 0;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = wr_if.wr_ready;
      tick();
    end
    check("held_write_done", 32'(acc), 32'h1);
    wr_if.wr_valid = 1'b0;

    // Reset in the middle of digit 3.
    do_reset();
    wait_dig("wait_digit3", 6'b001000, 300);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_dig", 32'(DIG), 32'h0);
    check("rst_seg", 32'(SEG), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all();
    for (int i = 1; i <= 3; i++) tick();
    check("post_rst_dig", 32'(DIG), 32'h01);
    check("post_rst_seg", 32'(SEG), 32'h3F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
